mips_control_fsm: RTL and testbench

- Multicycle main controller for the 32-bit MIPS core. Sits directly upstream of the ALU.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives ALUControl and operand selects to the ALU. Consumes the ALU zero flag to resolve branches.
- Moore outputs are decoded from the state register. Only pcEn also depends on zero.

---
 rtl/mips_control_fsm.sv | 94 +++++++++
 tb/tb_mips_control_fsm.sv | 136 +++++++++++++
 2 files changed

// File: rtl/mips_control_fsm.sv
// mips_control_fsm: multicycle MIPS main controller with Moore outputs decoded from state.
// Define MIPS_CTRL_BNE_EN to add the bne branch state (12).
module mips_control_fsm #(
  parameter int STATE_W = 4,
  parameter int CTRL_W  = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               pcEn,
  output logic               IorD,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSrc,
  output logic [CTRL_W-1:0]  ALUControl,
  output logic [STATE_W-1:0] state
);
  localparam logic [STATE_W-1:0] FETCH   = STATE_W'(0);
  localparam logic [STATE_W-1:0] DECODE  = STATE_W'(1);
  localparam logic [STATE_W-1:0] MEMADR  = STATE_W'(2);
  localparam logic [STATE_W-1:0] MEMRD   = STATE_W'(3);
  localparam logic [STATE_W-1:0] MEMWB   = STATE_W'(4);
  localparam logic [STATE_W-1:0] MEMWR   = STATE_W'(5);
  localparam logic [STATE_W-1:0] EXECUTE = STATE_W'(6);
  localparam logic [STATE_W-1:0] ALUWB   = STATE_W'(7);
  localparam logic [STATE_W-1:0] BEQ     = STATE_W'(8);
  localparam logic [STATE_W-1:0] ADDIEX  = STATE_W'(9);
  localparam logic [STATE_W-1:0] ADDIWB  = STATE_W'(10);
  localparam logic [STATE_W-1:0] JUMP    = STATE_W'(11);
  localparam logic [STATE_W-1:0] BNE     = STATE_W'(12);
  localparam logic [CTRL_W-1:0] ALU_ADD = CTRL_W'(5'b00010);
  localparam logic [CTRL_W-1:0] ALU_SUB = CTRL_W'(5'b00110);
  localparam logic [CTRL_W-1:0] ALU_AND = CTRL_W'(5'b00000);
  localparam logic [CTRL_W-1:0] ALU_OR  = CTRL_W'(5'b00001);
  localparam logic [CTRL_W-1:0] ALU_SLT = CTRL_W'(5'b00111);
`ifdef MIPS_CTRL_BNE_EN
  localparam logic BNE_EN = 1'b1;
`else
  localparam logic BNE_EN = 1'b0;
`endif
  logic [STATE_W-1:0] state_q, state_d, decode_d;
  logic [CTRL_W-1:0] funct_alu;
  logic is_beq, is_bne, pc_write;
  assign decode_d = (opcode == 6'b100011 || opcode == 6'b101011) ? MEMADR :
                    opcode == 6'b000000 ? EXECUTE :
                    opcode == 6'b000100 ? BEQ :
                    opcode == 6'b001000 ? ADDIEX :
                    opcode == 6'b000010 ? JUMP :
                    (BNE_EN && opcode == 6'b000101) ? BNE : FETCH;
  // Terminal states and unreachable encodings all fall back to FETCH.
  always_comb begin
    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE:  state_d = decode_d;
      MEMADR:  state_d = opcode == 6'b101011 ? MEMWR : MEMRD;
      MEMRD:   state_d = MEMWB;
      EXECUTE: state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end
  assign funct_alu = funct == 6'b100010 ? ALU_SUB :
                     funct == 6'b100100 ? ALU_AND :
                     funct == 6'b100101 ? ALU_OR  :
                     funct == 6'b101010 ? ALU_SLT : ALU_ADD;
  assign is_beq     = state_q == BEQ;
  assign is_bne     = BNE_EN && state_q == BNE;
  assign pc_write   = state_q == FETCH || state_q == JUMP;
  assign pcEn       = pc_write | (is_beq & zero) | (is_bne & ~zero);
  assign IorD       = state_q == MEMRD || state_q == MEMWR;
  assign MemWrite   = state_q == MEMWR;
  assign IRWrite    = state_q == FETCH;
  assign RegDst     = state_q == ALUWB;
  assign MemtoReg   = state_q == MEMWB;
  assign RegWrite   = state_q == MEMWB || state_q == ALUWB || state_q == ADDIWB;
  assign ALUSrcA    = state_q == MEMADR || state_q == EXECUTE || is_beq || state_q == ADDIEX || is_bne;
  assign ALUSrcB    = state_q == FETCH ? 2'b01 :
                      state_q == DECODE ? 2'b11 :
                      (state_q == MEMADR || state_q == ADDIEX) ? 2'b10 : 2'b00;
  assign PCSrc      = (is_beq || is_bne) ? 2'b01 : state_q == JUMP ? 2'b10 : 2'b00;
  assign ALUControl = state_q == EXECUTE ? funct_alu : (is_beq || is_bne) ? ALU_SUB : ALU_ADD;
  assign state      = state_q;
endmodule

// File: tb/tb_mips_control_fsm.sv
// tb_mips_control_fsm: random instruction stream checked against a table model of the controller.
module tb_mips_control_fsm;
  typedef struct packed {
    logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, src_a;
    logic [1:0] src_b, pc_src;
    logic [4:0] alu;
  } ctrl_t;
`ifdef MIPS_CTRL_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, zero = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic pcEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [4:0] ALUControl;
  logic [3:0] state;
  ctrl_t obs;
  int checks = 0, errors = 0;
  mips_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .pcEn(pcEn), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSrc(PCSrc), .ALUControl(ALUControl), .state(state)
  );
  always #5 clk = ~clk;
  assign obs = {pcEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, PCSrc, ALUControl};
  function automatic logic [4:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'h22:   return 5'b00110;
      6'h24:   return 5'b00000;
      6'h25:   return 5'b00001;
      6'h2a:   return 5'b00111;
      default: return 5'b00010;
    endcase
  endfunction
  // Expected control outputs for each named state, straight from the state table.
  function automatic ctrl_t exp_ctrl(input int st, input logic [5:0] fn, input logic z);
    ctrl_t c = '0;
    c.alu = 5'b00010;
    case (st)
      0:  begin c.ir_write = 1; c.pc_en = 1; c.src_b = 2'b01; end
      1:  c.src_b = 2'b11;
      2:  begin c.src_a = 1; c.src_b = 2'b10; end
      3:  c.iord = 1;
      4:  begin c.reg_write = 1; c.mem_to_reg = 1; end
      5:  begin c.iord = 1; c.mem_write = 1; end
      6:  begin c.src_a = 1; c.alu = alu_of(fn); end
      7:  begin c.reg_write = 1; c.reg_dst = 1; end
      8:  begin c.src_a = 1; c.alu = 5'b00110; c.pc_src = 2'b01; c.pc_en = z; end
      9:  begin c.src_a = 1; c.src_b = 2'b10; end
      10: c.reg_write = 1;
      11: begin c.pc_en = 1; c.pc_src = 2'b10; end
      12: begin c.src_a = 1; c.alu = 5'b00110; c.pc_src = 2'b01; c.pc_en = ~z; end
      default: ;
    endcase
    return c;
  endfunction
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
    int seq[$];
    seq = '{0, 1};
    case (op)
      6'h23:   seq = '{0, 1, 2, 3, 4};
      6'h2b:   seq = '{0, 1, 2, 5};
      6'h00:   seq = '{0, 1, 6, 7};
      6'h04:   seq = '{0, 1, 8};
      6'h08:   seq = '{0, 1, 9, 10};
      6'h02:   seq = '{0, 1, 11};
      6'h05:   if (BNE_EN) seq = '{0, 1, 12};
      default: ;
    endcase
    opcode = op;
    funct = fn;
    zero = z;
    foreach (seq[k]) begin
      chk($sformatf("state op=%h k=%0d", op, k), 32'(state), 32'(seq[k]));
      chk($sformatf("ctrl op=%h st=%0d z=%b", op, seq[k], z), 32'(obs), 32'(exp_ctrl(seq[k], fn, z)));
      step();
    end
    chk($sformatf("return op=%h", op), 32'(state), 32'd0);
  endtask
  initial begin
    logic [5:0] ops[8] = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h08, 6'h02, 6'h05, 6'h3f};
    logic [5:0] fns[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    zero = 1'b1;
    #12;
    chk("reset state", 32'(state), 32'd0);
    chk("reset ctrl", 32'(obs), 32'(exp_ctrl(0, 6'h00, 1'b1)));
    reset = 1'b0;
    run_instr(6'h23, 6'h00, 1'b0);
    run_instr(6'h2b, 6'h00, 1'b1);
    run_instr(6'h00, 6'h22, 1'b0);
    run_instr(6'h04, 6'h00, 1'b1);
    run_instr(6'h04, 6'h00, 1'b0);
    run_instr(6'h3f, 6'h00, 1'b0);
    run_instr(6'h02, 6'h00, 1'b0);
    run_instr(6'h05, 6'h00, 1'b0);
    run_instr(6'h05, 6'h00, 1'b1);
    run_instr(6'h08, 6'h2a, 1'b1);
    opcode = 6'h00;
    funct = 6'h22;
    zero = 1'b0;
    step();
    step();
    chk("pre-reset execute", 32'(state), 32'd6);
    #2;
    reset = 1'b1;
    #1;
    chk("async reset state", 32'(state), 32'd0);
    chk("async reset ctrl", 32'(obs), 32'(exp_ctrl(0, 6'h22, 1'b0)));
    step();
    chk("held reset state", 32'(state), 32'd0);
    chk("held reset strobes", 32'({MemWrite, RegWrite}), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 80; i++) begin
      logic [5:0] op, fn;
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
      fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      run_instr(op, fn, 1'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
